// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator result display.
// Glyph codes, segment patterns and FSM states.
package calc_pkg;

   typedef enum logic [1:0] {
      BLANK = 2'd0,
      HOLD  = 2'd1,
      SHOW  = 2'd2
   } state_t;

   // 4-bit glyph code: 0-9 digits, 10 minus, 11 E, 12 r, 15 blank
   typedef logic [3:0] glyph_t;

   localparam glyph_t G_MINUS = 4'd10;
   localparam glyph_t G_E     = 4'd11;
   localparam glyph_t G_R     = 4'd12;
   localparam glyph_t G_BLANK = 4'd15;

   // Active-low segments {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Glyph code to active-low 7-segment pattern.
// Purely combinational; unused codes render blank.
module seg7_decode
   import calc_pkg::*;
(
   input  glyph_t     i_glyph,
   output logic [6:0] o_seg
);

   // Look up the segment pattern for the glyph
   always_comb begin
      o_seg = SEG_BLANK;
      case (i_glyph)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         G_MINUS: o_seg = SEG_MINUS;
         G_E:     o_seg = SEG_E;
         G_R:     o_seg = SEG_R;
         default: o_seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/calc_result_display.sv
// Captures a sign-magnitude result via valid/ready with a minimum
// hold time and scans it onto a 3-digit multiplexed 7-seg display.
module calc_result_display
   import calc_pkg::*;
#(
   parameter int REFRESH_DIV = 1000,
   parameter int HOLD_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] result,
   input  logic       divbyzeroflag,
   input  logic       result_valid,
   output logic       result_ready,
   output logic [6:0] seg,
   output logic [2:0] an
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [HW-1:0]   r_hold;
   logic [HW-1:0]   w_hold_nxt;
   logic [PW-1:0]   r_pre;
   logic [1:0]      r_idx;
   logic [3:0]      r_mag;
   logic            r_neg;
   logic            r_err;
   logic            w_capture;
   logic            w_wrap;
   logic [3:0]      w_units;
   logic [3:0]      w_tens;
   glyph_t          w_glyph;
   logic [6:0]      w_seg;
   logic [6:0]      r_seg;
   logic [2:0]      r_an;

   assign w_capture = result_valid && result_ready;
   assign w_wrap    = (r_pre == PW'(REFRESH_DIV - 1));
   assign w_units   = r_mag % 4'd10;
   assign w_tens    = r_mag / 4'd10;
   assign seg       = r_seg;
   assign an        = r_an;

   // FSM state and hold counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= BLANK;
         r_hold  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
      end
   end

   // Next state, hold countdown and ready
   always_comb begin
      w_state_nxt  = r_state;
      w_hold_nxt   = r_hold;
      result_ready = (r_state != HOLD);
      case (r_state)
         HOLD: begin
            if (r_hold <= HW'(1)) begin
               w_state_nxt = SHOW;
               w_hold_nxt  = '0;
            end else begin
               w_hold_nxt  = r_hold - HW'(1);
            end
         end
         default: begin
            if (w_capture) begin
               w_state_nxt = HOLD;
               w_hold_nxt  = HW'(HOLD_CYCLES);
            end
         end
      endcase
   end

   // Latch the accepted result and error qualifier
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mag <= '0;
         r_neg <= 1'b0;
         r_err <= 1'b0;
      end else if (w_capture) begin
         r_mag <= result[3:0];
         r_neg <= result[4];
         r_err <= divbyzeroflag;
      end
   end

   // Prescaler and digit index; scanning never stops
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre <= '0;
         r_idx <= 2'd0;
      end else if (w_wrap) begin
         r_pre <= '0;
         r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
      end else begin
         r_pre <= r_pre + PW'(1);
      end
   end

   // Pick the glyph for the digit currently being scanned
   always_comb begin
      w_glyph = G_BLANK;
      if (r_err) begin
         w_glyph = (r_idx == 2'd2) ? G_E : G_R;
      end else begin
         case (r_idx)
            2'd0:    w_glyph = w_units;
            2'd1:    w_glyph = (w_tens == 4'd0) ? G_BLANK : w_tens;
            2'd2:    w_glyph = (r_neg && r_mag != 4'd0) ? G_MINUS : G_BLANK;
            default: w_glyph = G_BLANK;
         endcase
      end
   end

   seg7_decode u_dec (
      .i_glyph (w_glyph),
      .o_seg   (w_seg)
   );

   // Registered pin drivers; anodes dark while nothing is stored
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seg <= SEG_BLANK;
         r_an  <= 3'b111;
      end else begin
         r_seg <= w_seg;
         r_an  <= (r_state == BLANK) ? 3'b111 : ~(3'b001 << r_idx);
      end
   end

endmodule

// File: tb/tb_calc_result_display.sv
// Randomized + directed bench for calc_result_display.
// Reference model works from cycle counts since reset/capture.
module tb_calc_result_display;

   localparam int DIV  = 2;
   localparam int HOLD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] result = '0;
   logic       divbyzeroflag = 1'b0;
   logic       result_valid = 1'b0;
   logic       result_ready;
   logic [6:0] seg;
   logic [2:0] an;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   // model state
   int         m_cyc = 0;
   bit         m_has = 0;
   int         m_since = 0;
   int         m_mag = 0;
   bit         m_neg = 0;
   bit         m_err = 0;
   logic [6:0] m_seg = 7'h7F;
   logic [2:0] m_an = 3'b111;
   logic [6:0] dig [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   calc_result_display #(
      .REFRESH_DIV (DIV),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .result        (result),
      .divbyzeroflag (divbyzeroflag),
      .result_valid  (result_valid),
      .result_ready  (result_ready),
      .seg           (seg),
      .an            (an)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [6:0] glyph_seg(int idx, int mag, bit neg, bit err);
      if (err) return (idx == 2) ? 7'h06 : 7'h2F;
      case (idx)
         0:       return dig[mag % 10];
         1:       return (mag >= 10) ? dig[mag / 10] : 7'h7F;
         default: return (neg && mag != 0) ? 7'h3F : 7'h7F;
      endcase
   endfunction

   function automatic bit m_ready();
      return !m_has || (m_since >= HOLD);
   endfunction

   // reference model: advanced at every rising edge
   always @(posedge clk) begin
      if (rst) begin
         m_cyc = 0;
         m_has = 0;
         m_since = 0;
         m_mag = 0;
         m_neg = 0;
         m_err = 0;
         m_seg = 7'h7F;
         m_an = 3'b111;
      end else begin
         int idx;
         idx = (m_cyc / DIV) % 3;
         m_seg = glyph_seg(idx, m_mag, m_neg, m_err);
         m_an = m_has ? ~(3'b001 << idx) : 3'b111;
         if (result_valid && m_ready()) begin
            m_has = 1;
            m_since = 0;
            m_mag = int'(result[3:0]);
            m_neg = result[4];
            m_err = divbyzeroflag;
         end else if (m_since < 1000) begin
            m_since++;
         end
         m_cyc++;
      end
      chk_en = 1'b1;
   end

   // compare every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("seg", 32'(seg), 32'(m_seg));
         chk("an", 32'(an), 32'(m_an));
         chk("ready", 32'(result_ready), 32'(m_ready()));
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic put(logic [4:0] r, logic e);
      result = r;
      divbyzeroflag = e;
      result_valid = 1'b1;
      cyc(1);
      result_valid = 1'b0;
   endtask

   initial begin
      // reset
      cyc(2);
      rst = 1'b0;
      cyc(3);
      // negative six
      put(5'b10110, 1'b0);
      cyc(12);
      // divide by zero
      put(5'b00011, 1'b1);
      cyc(10);
      // valid held through HOLD
      put(5'd5, 1'b0);
      result = 5'd9;
      result_valid = 1'b1;
      cyc(6);
      result_valid = 1'b0;
      cyc(10);
      // boundary values
      put(5'b10000, 1'b0);
      cyc(8);
      put(5'b01100, 1'b0);
      cyc(8);
      put(5'b01111, 1'b0);
      cyc(8);
      // reset mid-HOLD, with a simultaneous capture
      put(5'b10111, 1'b0);
      cyc(1);
      rst = 1'b1;
      result = 5'd3;
      result_valid = 1'b1;
      cyc(1);
      rst = 1'b0;
      result_valid = 1'b0;
      cyc(4);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         result = 5'($urandom);
         divbyzeroflag = ($urandom_range(0, 7) == 0);
         result_valid = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 79) == 0);
         cyc(1);
      end
      rst = 1'b0;
      result_valid = 1'b0;
      cyc(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
